apb_slave_regfile: RTL and testbench



---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_reg_bank.sv | 45 ++++
 rtl/apb_slave_regfile.sv | 169 ++++++++++++++++
 tb/tb_apb_slave_regfile.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths, FSM state encoding and decode constants
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Byte address to word index shift (32-bit registers)
    localparam int WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - NUM_REGS x 32 register storage, single write port, combinational read
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS  = 8,
    parameter int                    IDX_W     = 3,
    parameter logic [APB_DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] regs [NUM_REGS];

    // Storage: every word returns to RESET_VAL on reset, one word written per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we && (widx == IDX_W'(i))) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Read port: an index past the last register (non power-of-two sizes) reads as zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx == IDX_W'(i)) begin
                rdata = regs[i];
            end
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB3 register-file completer with wait states; APB_SLVERR_EN enables pslverr on bad addresses
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS    = 8,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [APB_DATA_W-1:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    input  logic                  pwrite,
    input  logic                  psel,
    input  logic                  penable,
    output logic                  pready,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pslverr
);

    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int WORD_W = APB_ADDR_W - WORD_SHIFT;

    apb_state_t state, state_next;

    logic [3:0]            cnt;
    logic                  lat_valid;
    logic                  lat_write;
    logic [IDX_W-1:0]      lat_idx;
    logic [APB_DATA_W-1:0] lat_wdata;

    logic [APB_ADDR_W-1:0] off;
    logic [WORD_W-1:0]     word;
    logic                  dec_valid;
    logic [IDX_W-1:0]      dec_idx;

    logic                  setup;
    logic                  complete;
    logic                  cur_valid;
    logic                  cur_write;
    logic [IDX_W-1:0]      rd_idx;
    logic [APB_DATA_W-1:0] rd_data;
    logic [APB_DATA_W-1:0] resp_data;
    logic                  resp_err;
    logic                  bank_we;

    // Address decode on the live bus; only meaningful in the setup phase
    always_comb begin
        off       = paddr - BASE_ADDR;
        word      = off[APB_ADDR_W-1:WORD_SHIFT];
        dec_valid = (paddr >= BASE_ADDR) && (off[WORD_SHIFT-1:0] == '0) &&
                    (word < WORD_W'(NUM_REGS));
        dec_idx   = word[IDX_W-1:0];
    end

    // Response source: live decode when answering with zero wait states, latched transfer otherwise
    always_comb begin
        setup     = psel && !penable;
        complete  = (state == ACCESS) && psel && penable && pready && (cnt == 4'd0);
        cur_valid = (state == ACCESS) ? lat_valid : dec_valid;
        cur_write = (state == ACCESS) ? lat_write : pwrite;
        rd_idx    = (state == ACCESS) ? lat_idx   : dec_idx;
        resp_data = (cur_valid && !cur_write) ? rd_data : '0;
`ifdef APB_SLVERR_EN
        resp_err  = !cur_valid;
`else
        resp_err  = 1'b0;
`endif
        bank_we   = complete && lat_valid && lat_write;
    end

    apb_reg_bank #(
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bank_we),
        .widx  (lat_idx),
        .wdata (lat_wdata),
        .ridx  (rd_idx),
        .rdata (rd_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: DONE accepts a new setup phase so transfers can run back to back
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (setup) state_next = ACCESS;
            ACCESS: begin
                if (!psel)         state_next = IDLE;
                else if (complete) state_next = DONE;
            end
            DONE:    state_next = setup ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: transfer latch, wait counter and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            pready    <= 1'b0;
            prdata    <= '0;
            pslverr   <= 1'b0;
            lat_valid <= 1'b0;
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    pready  <= 1'b0;
                    prdata  <= '0;
                    pslverr <= 1'b0;
                    if (setup) begin
                        lat_valid <= dec_valid;
                        lat_write <= pwrite;
                        lat_idx   <= dec_idx;
                        lat_wdata <= pwdata;
                        cnt       <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            pready  <= 1'b1;
                            prdata  <= resp_data;
                            pslverr <= resp_err;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        cnt     <= 4'd0;
                        pready  <= 1'b0;
                        prdata  <= '0;
                        pslverr <= 1'b0;
                    end else if (cnt > 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end else if (cnt == 4'd1) begin
                        cnt     <= 4'd0;
                        pready  <= 1'b1;
                        prdata  <= resp_data;
                        pslverr <= resp_err;
                    end else if (complete) begin
                        pready  <= 1'b0;
                        prdata  <= '0;
                        pslverr <= 1'b0;
                    end
                end
                default: begin
                    cnt     <= 4'd0;
                    pready  <= 1'b0;
                    prdata  <= '0;
                    pslverr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - self-checking bench for apb_slave_regfile with 0, 1 and 3 wait states
module tb_apb_slave_regfile;

    localparam logic [31:0] RV = 32'hCAFE_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pwrite = 1'b0;
    logic        penable = 1'b0;
    logic [2:0]  psel = '0;
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [31:0] prdata [3];

    always #5 clk = ~clk;

    apb_slave_regfile #(.NUM_REGS(8), .BASE_ADDR(32'h0), .WAIT_CYCLES(0), .RESET_VAL(RV)) u_w0 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel[0]), .penable(penable), .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));
    apb_slave_regfile #(.NUM_REGS(8), .BASE_ADDR(32'h0), .WAIT_CYCLES(1), .RESET_VAL(RV)) u_w1 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel[1]), .penable(penable), .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));
    apb_slave_regfile #(.NUM_REGS(8), .BASE_ADDR(32'h0), .WAIT_CYCLES(3), .RESET_VAL(RV)) u_w3 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel[2]), .penable(penable), .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]));

    typedef struct {
        logic [31:0] rdata;
        logic        is_read;
        logic        err;
        int          acc;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        bad;
    } vec_t;

    exp_t        sb [$];
    logic [31:0] model [3][8];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic exp_err(input logic bad);
`ifdef APB_SLVERR_EN
        return bad;
`else
        return 1'b0 & bad;
`endif
    endfunction

    // Access-phase cycles up to and including the first pready=1 cycle
    function automatic int acc_n(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic is_bad(input logic [31:0] a);
        return (a >= 32'h20) || (a[1:0] != 2'b00);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 8; i++)
                model[d][i] = RV;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the completion edge
    task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input string nm);
        exp_t e;
        exp_t got;
        int   n;
        logic done;
        e.rdata   = exp_rd;
        e.is_read = !wr;
        e.err     = exp_err(is_bad(a));
        e.acc     = acc_n(d);
        sb.push_back(e);
        paddr   = a;
        pwdata  = wd;
        pwrite  = wr;
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        @(negedge clk);
        check($sformatf("%s setup_pready", nm), {31'b0, pready[d]}, 32'd0);
        @(posedge clk);
        #1 penable = 1'b1;
        n    = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (pready[d]) begin
                done = 1'b1;
                got  = sb.pop_front();
                check($sformatf("%s access_cycles", nm), n, got.acc);
                check($sformatf("%s pslverr", nm), {31'b0, pslverr[d]}, {31'b0, got.err});
                if (got.is_read)
                    check($sformatf("%s prdata", nm), prdata[d], got.rdata);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no pready required pready within 20 cycles", nm);
            void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        psel    = '0;
        penable = 1'b0;
        if (wr && !is_bad(a))
            model[d][a[4:2]] = wd;
    endtask

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h04, 32'h1234_5678, 32'h0,         1'b0};
        tbl[1] = '{1'b0, 32'h04, 32'h0,         32'h1234_5678, 1'b0};
        tbl[2] = '{1'b0, 32'h00, 32'h0,         RV,            1'b0};
        tbl[3] = '{1'b0, 32'h1C, 32'h0,         RV,            1'b0};
        tbl[4] = '{1'b1, 32'h20, 32'h1111_1111, 32'h0,         1'b1};
        tbl[5] = '{1'b1, 32'h06, 32'h2222_2222, 32'h0,         1'b1};
        tbl[6] = '{1'b0, 32'h20, 32'h0,         32'h0,         1'b1};
        tbl[7] = '{1'b0, 32'h06, 32'h0,         32'h0,         1'b1};
        tbl[8] = '{1'b0, 32'h04, 32'h0,         32'h1234_5678, 1'b0};
        tbl[9] = '{1'b0, 32'h00, 32'h0,         RV,            1'b0};
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset pready%0d", d), {31'b0, pready[d]}, 32'd0);
            check($sformatf("reset prdata%0d", d), prdata[d], 32'd0);
            check($sformatf("reset pslverr%0d", d), {31'b0, pslverr[d]}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors on the one-wait-state instance
        for (int i = 0; i < 10; i++) begin
            xfer(1, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, $sformatf("vec%0d", i));
            if (tbl[i].bad != is_bad(tbl[i].addr))
                $display("vector %0d bad flag inconsistent", i);
        end

        // Zero and three wait states
        xfer(0, 1'b1, 32'h0, 32'hAAAA_0000, 32'h0, "w0_write");
        xfer(0, 1'b0, 32'h0, 32'h0, model[0][0], "w0_read");
        xfer(2, 1'b1, 32'h0, 32'hBBBB_0003, 32'h0, "w3_write");
        xfer(2, 1'b0, 32'h0, 32'h0, model[2][0], "w3_read");
        @(posedge clk);
        #1;

        // Abort: psel dropped during the second wait cycle
        paddr = 32'h8; pwdata = 32'h55AA_55AA; pwrite = 1'b1; psel = 3'b100; penable = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        @(posedge clk);
        #1 psel = '0; penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("abort pready c%0d", i), {31'b0, pready[2]}, 32'd0);
        end
        @(posedge clk);
        #1;
        xfer(2, 1'b0, 32'h8, 32'h0, RV, "abort_readback");

        // Back-to-back writes then readback
        xfer(1, 1'b1, 32'h0, 32'h1000_0000, 32'h0, "b2b_w0");
        xfer(1, 1'b1, 32'h4, 32'h1000_0004, 32'h0, "b2b_w4");
        xfer(1, 1'b1, 32'h8, 32'h1000_0008, 32'h0, "b2b_w8");
        xfer(1, 1'b0, 32'h0, 32'h0, 32'h1000_0000, "b2b_r0");
        xfer(1, 1'b0, 32'h4, 32'h0, 32'h1000_0004, "b2b_r4");
        xfer(1, 1'b0, 32'h8, 32'h0, 32'h1000_0008, "b2b_r8");

        // Reset pulsed while pready is high in the access phase
        xfer(1, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0, "pre_reset_write");
        paddr = 32'h8; pwrite = 1'b0; psel = 3'b010; penable = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_access pready", {31'b0, pready[1]}, 32'd1);
        check("mid_access prdata", prdata[1], 32'hDEAD_BEEF);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset pready", {31'b0, pready[1]}, 32'd0);
        check("async_reset prdata", prdata[1], 32'd0);
        psel = '0;
        penable = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(1, 1'b0, 32'h8, 32'h0, RV, "post_reset_read");

        check("scoreboard empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
